// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory port arbiter: port owner encoding and the full byte-enable mask.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_FETCH,
        OWNER_DATA
    } t_mem_owner;

    localparam logic [3:0] MEM_BE_ALL = 4'hF;

endpackage

// File: rtl/memory_arbiter_slot_timer.sv
// Times one memory access slot: counts 0..WAIT_STATES while the port is owned, flags the last cycle.
module memory_arbiter_slot_timer #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic last
);

    logic [3:0] count_q, count_d;

    assign last = busy && (count_q == 4'(WAIT_STATES));

    always_comb begin
        count_d = '0;
        if (!start && busy && !last) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single memory port between instruction fetch and load/store; data has priority
// but fetch gets a slot after MAX_DATA_RUN consecutive data grants.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned ADDR_WIDTH   = 30
) (
    input  logic                  reset,
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    input  logic                  halting,
    output logic                  fetch_advance,
    output logic                  block_fetch,
    input  logic                  data_req,
    input  logic                  data_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [31:0]           data_wdata,
    input  logic [3:0]            data_be,
    output logic                  data_ack,
    output logic [31:0]           data_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    t_mem_owner owner_q, owner_d;
    logic [RUN_W-1:0] run_q;
    logic slot_last, decide, grant_data, grant_fetch;

    memory_arbiter_slot_timer #(
        .WAIT_STATES(WAIT_STATES)
    ) u_slot_timer (
        .clock(clock),
        .reset(reset),
        .start(grant_data || grant_fetch),
        .busy (owner_q != OWNER_NONE),
        .last (slot_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Halting lets data through even past the run limit, since no fetch is waiting.
    always_comb begin
        decide  = (owner_q == OWNER_NONE) || slot_last;
        owner_d = owner_q;
        if (decide) begin
            if (data_req && ((run_q < RUN_MAX) || halting)) begin
                owner_d = OWNER_DATA;
            end else if (!halting) begin
                owner_d = OWNER_FETCH;
            end else begin
                owner_d = OWNER_NONE;
            end
        end
        grant_data  = decide && (owner_d == OWNER_DATA);
        grant_fetch = decide && (owner_d == OWNER_FETCH);
    end

    always_comb begin
        fetch_advance = (owner_q == OWNER_FETCH) && slot_last;
        block_fetch   = !fetch_advance;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q       <= '0;
            data_ack    <= 1'b0;
            data_rdata  <= '0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_be      <= '0;
            mem_wdata   <= '0;
        end else begin
            data_ack <= (owner_q == OWNER_DATA) && slot_last;
            if ((owner_q == OWNER_DATA) && slot_last && !mem_write) begin
                data_rdata <= mem_rdata;
            end
            if (grant_data) begin
                mem_address <= data_address;
                mem_read    <= !data_write;
                mem_write   <= data_write;
                mem_be      <= data_be;
                mem_wdata   <= data_wdata;
                if (run_q != RUN_MAX) begin
                    run_q <= run_q + RUN_W'(1);
                end
            end else if (grant_fetch) begin
                mem_address <= fetch_address;
                mem_read    <= 1'b1;
                mem_write   <= 1'b0;
                mem_be      <= MEM_BE_ALL;
                run_q       <= '0;
            end else if (decide) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

endmodule
